// File: rtl/rxecrc.sv
// Receive-side CRC-32 checker: runs IEEE 802.3 CRC over each frame including
// its FCS, strips the 4 FCS bytes from the output and flags bad/runt/PHY-error frames.
module rxecrc #(
  parameter logic [31:0] TAPS    = 32'hedb88320,
  parameter logic [31:0] RESIDUE = 32'hdebb20e3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  input  logic       i_err,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_err
);

  // One byte of LSB-first reflected CRC division, unrolled into 8 shift steps.
  function automatic logic [31:0] crc_table(input logic [7:0] idx);
    logic [31:0] r;
    r = {24'h000000, idx};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) begin
        r = {1'b0, r[31:1]} ^ TAPS;
      end else begin
        r = {1'b0, r[31:1]};
      end
    end
    return r;
  endfunction

  logic [31:0] crc_q, crc_d;
  logic [31:0] dly_q, dly_d;     // byte delay line, [31:24] is the oldest entry
  logic [2:0]  fill_q, fill_d;
  logic        sticky_q, sticky_d;
  logic        active_q, active_d;
  logic        en_q, en_d;
  logic        o_v_q, o_v_d;
  logic [7:0]  o_d_q, o_d_d;
  logic        o_err_q, o_err_d;
  logic        en_eff_s;

  // Mode for the current byte: the live i_en on the first byte, the latched one after.
  always_comb begin
    en_eff_s = en_q;
    if (active_q) begin
      en_eff_s = en_q;
    end else begin
      en_eff_s = i_en;
    end
  end

  // Next-state logic for CRC, delay line, frame tracking and registered outputs.
  always_comb begin
    crc_d    = crc_q;
    dly_d    = dly_q;
    fill_d   = fill_q;
    sticky_d = sticky_q;
    active_d = active_q;
    en_d     = en_q;
    o_v_d    = o_v_q;
    o_d_d    = o_d_q;
    o_err_d  = o_err_q;
    if (i_ce) begin
      if (i_v) begin
        crc_d    = {8'h00, crc_q[31:8]} ^ crc_table(crc_q[7:0] ^ i_d);
        sticky_d = sticky_q | i_err;
        active_d = 1'b1;
        en_d     = en_eff_s;
        o_err_d  = 1'b0;
        if (en_eff_s) begin
          dly_d = {dly_q[23:0], i_d};
          if (fill_q == 3'd4) begin
            o_v_d = 1'b1;
            o_d_d = dly_q[31:24];
          end else begin
            o_v_d  = 1'b0;
            fill_d = fill_q + 3'd1;
          end
        end else begin
          o_v_d = 1'b1;
          o_d_d = i_d;
        end
      end else if (active_q) begin
        // End of frame: the error flag is only meaningful for this one i_ce period.
        o_v_d    = 1'b0;
        o_d_d    = 8'h00;
        o_err_d  = sticky_q | (en_q & ((fill_q < 3'd4) | (crc_q != RESIDUE)));
        crc_d    = 32'hffffffff;
        fill_d   = 3'd0;
        sticky_d = 1'b0;
        active_d = 1'b0;
      end else begin
        o_v_d   = 1'b0;
        o_err_d = 1'b0;
      end
    end else begin
      o_v_d = o_v_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q    <= 32'hffffffff;
      dly_q    <= 32'h00000000;
      fill_q   <= 3'd0;
      sticky_q <= 1'b0;
      active_q <= 1'b0;
      en_q     <= 1'b0;
      o_v_q    <= 1'b0;
      o_d_q    <= 8'h00;
      o_err_q  <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      dly_q    <= dly_d;
      fill_q   <= fill_d;
      sticky_q <= sticky_d;
      active_q <= active_d;
      en_q     <= en_d;
      o_v_q    <= o_v_d;
      o_d_q    <= o_d_d;
      o_err_q  <= o_err_d;
    end
  end

  assign o_v   = o_v_q;
  assign o_d   = o_d_q;
  assign o_err = o_err_q;

endmodule

// File: tb/tb_rxecrc.sv
// Directed bench for rxecrc: good, corrupted, runt, pass-through, stalled,
// back-to-back and reset-aborted frames against hand-derived expectations.
module tb_rxecrc;
  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_ce;
  logic       i_en;
  logic       i_v;
  logic [7:0] i_d;
  logic       i_err;
  logic       o_v;
  logic [7:0] o_d;
  logic       o_err;

  int vecs = 0;
  int errs = 0;
  logic [7:0] fr [0:12];

  rxecrc dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
    .i_v(i_v), .i_d(i_d), .i_err(i_err),
    .o_v(o_v), .o_d(o_d), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic ce, input logic v, input logic [7:0] d, input logic err);
    i_ce  = ce;
    i_v   = v;
    i_d   = d;
    i_err = err;
    @(posedge i_clk);
    #1;
  endtask

  // "123456789" followed by its FCS, least significant CRC byte first.
  task automatic load_good();
    fr[0] = 8'h31; fr[1] = 8'h32; fr[2]  = 8'h33; fr[3]  = 8'h34; fr[4] = 8'h35;
    fr[5] = 8'h36; fr[6] = 8'h37; fr[7]  = 8'h38; fr[8]  = 8'h39;
    fr[9] = 8'h26; fr[10] = 8'h39; fr[11] = 8'hF4; fr[12] = 8'hCB;
  endtask

  // One frame of n bytes; i_en is flipped after the first byte to show it is latched.
  task automatic run_frame(input logic en, input int n, input int errpos,
                           input logic exp_err, input logic stall);
    logic       ev;
    logic [7:0] ed;
    for (int k = 0; k < n; k++) begin
      i_en = (k == 0) ? en : ~en;
      tick(1'b1, 1'b1, fr[k], (k == errpos));
      if (en) begin
        ev = (k >= 4);
        ed = (k >= 4) ? fr[k-4] : 8'h00;
      end else begin
        ev = 1'b1;
        ed = fr[k];
      end
      chk("byte_v", o_v, ev);
      if (ev) chk("byte_d", o_d, ed);
      chk("byte_err", o_err, 1'b0);
      if (stall) begin
        tick(1'b0, 1'b1, fr[k], 1'b0);
        chk("stall_v", o_v, ev);
        if (ev) chk("stall_d", o_d, ed);
      end
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("eof_v", o_v, 1'b0);
    chk("eof_d", o_d, 8'h00);
    chk("eof_err", o_err, exp_err);
    if (stall) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      chk("eof_err_hold", o_err, exp_err);
    end
  endtask

  task automatic idle_chk();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("idle_v", o_v, 1'b0);
    chk("idle_err", o_err, 1'b0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_en    = 1'b0;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_v", o_v, 1'b0);
    chk("rst_d", o_d, 8'h00);
    chk("rst_err", o_err, 1'b0);
    i_reset = 1'b0;
    idle_chk();

    load_good();
    run_frame(1'b1, 13, -1, 1'b0, 1'b0);
    idle_chk();

    fr[4] = 8'h75;
    run_frame(1'b1, 13, -1, 1'b1, 1'b0);
    idle_chk();

    fr[0] = 8'hAA; fr[1] = 8'hBB; fr[2] = 8'hCC;
    run_frame(1'b1, 3, -1, 1'b1, 1'b0);
    idle_chk();

    load_good();
    run_frame(1'b0, 13, -1, 1'b0, 1'b0);
    idle_chk();
    run_frame(1'b0, 13, 5, 1'b1, 1'b0);
    idle_chk();

    run_frame(1'b1, 13, -1, 1'b0, 1'b1);
    run_frame(1'b1, 13, -1, 1'b0, 1'b1);
    idle_chk();

    i_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b1, fr[k], 1'b0);
    end
    chk("pre_rst_v", o_v, 1'b1);
    chk("pre_rst_d", o_d, fr[1]);
    i_reset = 1'b1;
    tick(1'b1, 1'b1, fr[6], 1'b0);
    chk("midrst_v", o_v, 1'b0);
    chk("midrst_d", o_d, 8'h00);
    chk("midrst_err", o_err, 1'b0);
    i_reset = 1'b0;
    idle_chk();
    run_frame(1'b1, 13, -1, 1'b0, 1'b0);
    idle_chk();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
